// File: rtl/rx_data_buffer.sv
// Receive-side FIFO between the UART receiver and its consumer, with registered read port.
// Optional macro RX_BUF_ERR_EN stores a per-word receive-error flag alongside the data.
module rx_data_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Rx_DATA,
  input  logic              Rx_VALID,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  input  logic              clr_overrun,
`ifdef RX_BUF_ERR_EN
  input  logic              Rx_ERROR,
  output logic              rd_err,
`endif
  output logic              overrun
);

`ifdef RX_BUF_ERR_EN
  localparam int unsigned EntryW = DATA_W + 1;
`else
  localparam int unsigned EntryW = DATA_W;
`endif

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              push, pop, drop;

`ifdef RX_BUF_ERR_EN
  assign wr_entry = {Rx_ERROR, Rx_DATA};
`else
  assign wr_entry = Rx_DATA;
`endif
  assign rd_entry = mem_q[rd_ptr_q];

  // Gating with reset keeps a strobe in the reset cycle out of storage.
  assign pop  = reset & rd_en & ~empty_q;
  assign push = reset & Rx_VALID & (~full_q | pop);
  assign drop = reset & Rx_VALID & full_q & ~pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= pop;
      if (pop) rd_data_q <= rd_entry[DATA_W-1:0];
    end
  end

`ifdef RX_BUF_ERR_EN
  logic rd_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_err_q <= 1'b0;
    end else if (pop) begin
      rd_err_q <= rd_entry[DATA_W];
    end
  end

  assign rd_err = rd_err_q;
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_rx_data_buffer.sv
// Scoreboard bench for rx_data_buffer: a queue model predicts each read, checked on rd_valid.
// Define RX_BUF_ERR_EN to also exercise the per-word error flag.
module tb_rx_data_buffer;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] Rx_DATA = '0;
  logic              Rx_VALID = 1'b0;
  logic              rd_en = 1'b0;
  logic              clr_overrun = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
`ifdef RX_BUF_ERR_EN
  logic              Rx_ERROR = 1'b0;
  logic              rd_err;
`endif

  rx_data_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .clr_overrun(clr_overrun),
`ifdef RX_BUF_ERR_EN
    .Rx_ERROR   (Rx_ERROR),
    .rd_err     (rd_err),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Entries are {err, data}; err is always 0 when the flag feature is off.
  logic [DATA_W:0] mdl[$];
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] m_rd  = '0;
  logic            m_ovr = 1'b0;
  logic            m_rdv = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DATA_W:0] e;
    check_eq({tag, ":count"},    32'(count),    32'(mdl.size()));
    check_eq({tag, ":empty"},    32'(empty),    32'(mdl.size() == 0));
    check_eq({tag, ":full"},     32'(full),     32'(mdl.size() == DEPTH));
    check_eq({tag, ":overrun"},  32'(overrun),  32'(m_ovr));
    check_eq({tag, ":rd_valid"}, 32'(rd_valid), 32'(m_rdv));
    check_eq({tag, ":rd_data"},  32'(rd_data),  32'(m_rd[DATA_W-1:0]));
`ifdef RX_BUF_ERR_EN
    check_eq({tag, ":rd_err"},   32'(rd_err),   32'(m_rd[DATA_W]));
`endif
    if (rd_valid) begin
      check_eq({tag, ":sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq({tag, ":sb_data"}, 32'(rd_data), 32'(e[DATA_W-1:0]));
`ifdef RX_BUF_ERR_EN
        check_eq({tag, ":sb_err"}, 32'(rd_err), 32'(e[DATA_W]));
`endif
      end
    end
  endtask

  task automatic cycle(input string tag, input logic vld, input logic [DATA_W-1:0] d,
                       input logic err, input logic rd, input logic clr);
    logic full_m, empty_m, pop, push, drop;
    Rx_VALID    = vld;
    Rx_DATA     = d;
    rd_en       = rd;
    clr_overrun = clr;
`ifdef RX_BUF_ERR_EN
    Rx_ERROR    = err;
`endif
    empty_m = (mdl.size() == 0);
    full_m  = (mdl.size() == DEPTH);
    pop  = rd && !empty_m;
    push = vld && (!full_m || pop);
    drop = vld && full_m && !pop;
    m_rdv = pop;
    if (pop) begin
      m_rd = mdl.pop_front();
      exp_q.push_back(m_rd);
    end
`ifdef RX_BUF_ERR_EN
    if (push) mdl.push_back({err, d});
`else
    if (push) mdl.push_back({1'b0, d});
`endif
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    Rx_VALID    = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    check_state(tag);
  endtask

  // Strobes held high during reset must be ignored.
  task automatic do_reset(input int n);
    reset    = 1'b0;
    Rx_VALID = 1'b1;
    Rx_DATA  = 8'hEE;
    rd_en    = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset    = 1'b1;
    Rx_VALID = 1'b0;
    rd_en    = 1'b0;
    mdl.delete();
    exp_q.delete();
    m_ovr = 1'b0;
    m_rd  = '0;
    m_rdv = 1'b0;
    check_state("reset");
  endtask

  initial begin
    do_reset(2);

    // Basic ordering and hold after the last read.
    cycle("push", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle("push", 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle("push", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle("read", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle("hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Overflow drops the fifth word and sets sticky overrun.
    for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    cycle("ovr_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle("ovr_setwin", 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle("drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Simultaneous push/pop while full, across many pointer wraps.
    for (int i = 0; i < 4; i++) cycle("fill2", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cycle("full_rw", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle("wrap_rw", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
    repeat (5) cycle("drain2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Empty with push and read together: no fall-through.
    cycle("empty_rw", 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
    cycle("read_7e", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle("rd_empty", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Error flag travels with its word.
    cycle("err_push", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    cycle("err_push", 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle("err_read", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset with words stored discards them.
    cycle("pre_rst", 1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
    cycle("pre_rst", 1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    do_reset(1);
    cycle("post_rst", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Random traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    repeat (5) cycle("final", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
